// File: rtl/mips_mc_ctrl_fsm_if.sv
// Control bundle between the multicycle MIPS main FSM and the datapath it steers.
// master = the FSM side, slave = the datapath side.
interface mips_mc_ctrl_fsm_if;
    logic [5:0] op;
    logic       zero;
    logic [3:0] state;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal_op;

    modport master (
        input  op, zero,
        output state, pcen, irwrite, regwrite, memwrite, iord, memtoreg,
               regdst, alusrca, alusrcb, aluop, pcsrc, illegal_op
    );

    modport slave (
        output op, zero,
        input  state, pcen, irwrite, regwrite, memwrite, iord, memtoreg,
               regdst, alusrca, alusrcb, aluop, pcsrc, illegal_op
    );
endinterface

// File: rtl/mips_mc_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath steering and enables.
module mips_mc_ctrl_fsm (
    input  logic               clk,
    input  logic               reset,
    mips_mc_ctrl_fsm_if.master ctrl
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   pcwrite;
    logic   branch;
    logic   op_ok;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        op_ok = ctrl.op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            // IR is only written in FETCH, so op is still the decoded instruction here
            MEMADR:  state_d = (ctrl.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pcwrite       = 1'b0;
        branch        = 1'b0;
        ctrl.irwrite  = 1'b0;
        ctrl.regwrite = 1'b0;
        ctrl.memwrite = 1'b0;
        ctrl.iord     = 1'b0;
        ctrl.memtoreg = 1'b0;
        ctrl.regdst   = 1'b0;
        ctrl.alusrca  = 1'b0;
        ctrl.alusrcb  = '0;
        ctrl.aluop    = '0;
        ctrl.pcsrc    = '0;
        case (state_q)
            FETCH: begin
                ctrl.irwrite = 1'b1;
                pcwrite      = 1'b1;
                ctrl.alusrcb = 2'b01;
            end
            DECODE:  ctrl.alusrcb = 2'b11;
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            MEMRD:   ctrl.iord = 1'b1;
            MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b10;
            end
            RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b01;
                ctrl.pcsrc   = 2'b01;
                branch       = 1'b1;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            ADDIWB:  ctrl.regwrite = 1'b1;
            JEX: begin
                ctrl.pcsrc = 2'b10;
                pcwrite    = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl.state      = state_q;
    assign ctrl.pcen       = pcwrite | (branch & ctrl.zero);
    assign ctrl.illegal_op = (state_q == DECODE) & ~op_ok;
endmodule
